// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue controller: FSM state
// encoding, ALU control codes and the default datapath width.
package alu_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  // ALU control codes; NOP is what the ALU sees whenever nothing is issued.
  localparam logic [5:0] ALU_NOP = 6'h00;
  localparam logic [5:0] ALU_ADD = 6'h01;
  localparam logic [5:0] ALU_SUB = 6'h02;
  localparam logic [5:0] ALU_MUL = 6'h0A;
  localparam logic [5:0] ALU_DIV = 6'h0C;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Bundle of the decode-side handshake, the ALU drive/return signals and
// the writeback-side handshake. slave = issue controller, master = its
// environment (decode stage, ALU and writeback stage together).
interface alu_issue_ctrl_if
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  // decode side
  logic                         in_valid;
  logic                         in_ready;
  logic [5:0]                   in_ctrl;
  logic signed [DATA_WIDTH-1:0] in_op_a;
  logic signed [DATA_WIDTH-1:0] in_op_b;
  logic [4:0]                   in_rd;

  // toward the ALU
  logic [5:0]                   ALU_Control;
  logic signed [DATA_WIDTH-1:0] operand_A;
  logic signed [DATA_WIDTH-1:0] operand_B;

  // back from the ALU
  logic signed [DATA_WIDTH-1:0] ALU_result;
  logic signed [DATA_WIDTH-1:0] JALR_target;
  logic                         Branch_taken;
  logic                         hold_pipeline;
  logic                         ex;
  logic                         pc_s_a_1;
  logic                         zero;

  // writeback side
  logic                         out_valid;
  logic                         out_ready;
  logic [DATA_WIDTH-1:0]        out_result;
  logic [DATA_WIDTH-1:0]        out_jalr_target;
  logic                         out_branch_taken;
  logic                         out_ex;
  logic                         out_pc_s_a_1;
  logic                         out_zero;
  logic [4:0]                   out_rd;

  modport slave (
    input  in_valid, in_ctrl, in_op_a, in_op_b, in_rd,
    output in_ready,
    output ALU_Control, operand_A, operand_B,
    input  ALU_result, JALR_target, Branch_taken, hold_pipeline, ex, pc_s_a_1, zero,
    output out_valid, out_result, out_jalr_target, out_branch_taken, out_ex,
           out_pc_s_a_1, out_zero, out_rd,
    input  out_ready
  );

  modport master (
    output in_valid, in_ctrl, in_op_a, in_op_b, in_rd,
    input  in_ready,
    input  ALU_Control, operand_A, operand_B,
    output ALU_result, JALR_target, Branch_taken, hold_pipeline, ex, pc_s_a_1, zero,
    input  out_valid, out_result, out_jalr_target, out_branch_taken, out_ex,
           out_pc_s_a_1, out_zero, out_rd,
    output out_ready
  );

endinterface

// File: rtl/hold_timer.sv
// Saturating count of consecutive ALU hold cycles. o_expire flags the hold
// cycle that brings the count up to MAX_HOLD, so the caller can give up on
// the ALU in that same cycle.
module hold_timer
  import alu_pkg::*;
#(
  parameter int MAX_HOLD = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_expire
);

  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  logic [CNT_W-1:0] r_count;

  // count held cycles, clear on request, never run past MAX_HOLD
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != CNT_W'(MAX_HOLD))) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_expire = i_inc && (r_count == CNT_W'(MAX_HOLD - 1));

endmodule

// File: rtl/alu_issue_ctrl.sv
// Single-entry issue stage in front of a multi-cycle ALU: latches one op
// from decode, holds it steady on the ALU inputs while the ALU stalls,
// captures the ALU outputs and presents them to writeback.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int MAX_HOLD   = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  output logic            timeout_err,
  alu_issue_ctrl_if.slave bus
);

  state_t r_state;
  state_t w_state_next;

  // issue register
  logic [5:0]                   r_ctrl;
  logic signed [DATA_WIDTH-1:0] r_op_a;
  logic signed [DATA_WIDTH-1:0] r_op_b;
  logic [4:0]                   r_rd;

  // result register
  logic [DATA_WIDTH-1:0] r_result;
  logic [DATA_WIDTH-1:0] r_jalr;
  logic                  r_branch;
  logic                  r_ex;
  logic                  r_pcsa1;
  logic                  r_zero;
  logic                  r_timeout_err;

  logic w_accept;
  logic w_capture;
  logic w_hold_inc;
  logic w_hold_clr;
  logic w_timeout;
  logic w_rdy;

  // event decode shared by the FSM and the datapath registers; flush masks all of them
  always_comb begin
    w_hold_inc = !flush && (r_state == ST_BUSY) && bus.hold_pipeline;
    w_capture  = !flush && (r_state == ST_BUSY) && (!bus.hold_pipeline || w_timeout);
    w_accept   = !flush && bus.in_valid &&
                 ((r_state == ST_IDLE) || ((r_state == ST_DONE) && bus.out_ready));
    w_hold_clr = !w_hold_inc || w_capture;
  end

  hold_timer #(
    .MAX_HOLD (MAX_HOLD)
  ) u_hold_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_inc    (w_hold_inc),
    .i_clr    (w_hold_clr),
    .o_expire (w_timeout)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.in_valid) w_state_next = ST_BUSY;
        ST_BUSY: if (w_capture) w_state_next = ST_DONE;
        ST_DONE: begin
          if (bus.out_ready) w_state_next = bus.in_valid ? ST_BUSY : ST_IDLE;
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // FSM outputs; in_ready is held low while in reset and while flushing,
  // since nothing offered then can be taken
  always_comb begin
    w_rdy           = 1'b0;
    bus.ALU_Control = ALU_NOP;
    bus.operand_A   = '0;
    bus.operand_B   = '0;
    case (r_state)
      ST_IDLE: w_rdy = 1'b1;
      ST_BUSY: begin
        bus.ALU_Control = r_ctrl;
        bus.operand_A   = r_op_a;
        bus.operand_B   = r_op_b;
      end
      ST_DONE: w_rdy = bus.out_ready;
      default: w_rdy = 1'b0;
    endcase
    bus.in_ready  = rst_n && !flush && w_rdy;
    bus.out_valid = (r_state == ST_DONE);
  end

  // issue register: loads on accept, otherwise frozen until flushed
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_ctrl <= ALU_NOP;
      r_op_a <= '0;
      r_op_b <= '0;
      r_rd   <= '0;
    end else if (w_accept) begin
      r_ctrl <= bus.in_ctrl;
      r_op_a <= bus.in_op_a;
      r_op_b <= bus.in_op_b;
      r_rd   <= bus.in_rd;
    end
  end

  // result register: snapshot of the ALU outputs; a timed-out op is marked as an exception
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_result <= '0;
      r_jalr   <= '0;
      r_branch <= 1'b0;
      r_ex     <= 1'b0;
      r_pcsa1  <= 1'b0;
      r_zero   <= 1'b0;
    end else if (w_capture) begin
      r_result <= bus.ALU_result;
      r_jalr   <= bus.JALR_target;
      r_branch <= bus.Branch_taken;
      r_ex     <= bus.ex || w_timeout;
      r_pcsa1  <= bus.pc_s_a_1;
      r_zero   <= bus.zero;
    end
  end

  // sticky timeout flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_timeout_err <= 1'b0;
    end else if (w_capture && w_timeout) begin
      r_timeout_err <= 1'b1;
    end
  end

  assign timeout_err          = r_timeout_err;
  assign bus.out_result       = r_result;
  assign bus.out_jalr_target  = r_jalr;
  assign bus.out_branch_taken = r_branch;
  assign bus.out_ex           = r_ex;
  assign bus.out_pc_s_a_1     = r_pcsa1;
  assign bus.out_zero         = r_zero;
  assign bus.out_rd           = r_rd;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: a directed vector table, hand
// sequences for timeout / flush / reset, and randomized ops. The bench
// plays the ALU with a behavioural stub and predicts every result from
// its own record of the issued op.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int DW       = 32;
  localparam int MAX_HOLD = 64;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] jalr;
    logic        br;
    logic        ex;
    logic        ps;
    logic        z;
  } res_t;

  typedef struct packed {
    logic [5:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    int          holds;
    int          bp;
    logic        b2b;
    res_t        exp;
  } vec_t;

  logic clk;
  logic rst_n;
  logic flush;
  logic timeout_err;
  int   n_cmp = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  alu_issue_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  alu_issue_ctrl #(
    .DATA_WIDTH (DW),
    .MAX_HOLD   (MAX_HOLD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .timeout_err (timeout_err),
    .bus         (bus.slave)
  );

  // behavioural ALU: what a real ALU would answer for (ctrl, a, b)
  function automatic res_t alu_fn(input logic [5:0] c, input logic signed [31:0] a,
                                  input logic signed [31:0] b);
    res_t r;
    logic signed [31:0] v;
    r = '0;
    v = 0;
    case (c)
      ALU_ADD: v = a + b;
      ALU_SUB: v = a - b;
      ALU_MUL: v = a * b;
      ALU_DIV: begin
        if (b == 0) begin
          v    = -1;
          r.ex = 1'b1;
        end else begin
          v = a / b;
        end
      end
      default: v = 0;
    endcase
    r.res  = v;
    r.jalr = (a + b) & ~32'd1;
    r.br   = (v < 0);
    r.ps   = (a < b);
    r.z    = (v == 0);
    return r;
  endfunction

  res_t alu_s;
  always_comb alu_s = alu_fn(bus.ALU_Control, bus.operand_A, bus.operand_B);
  assign bus.ALU_result   = alu_s.res;
  assign bus.JALR_target  = alu_s.jalr;
  assign bus.Branch_taken = alu_s.br;
  assign bus.ex           = alu_s.ex;
  assign bus.pc_s_a_1     = alu_s.ps;
  assign bus.zero         = alu_s.z;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // offer one op; it must be taken at the next edge
  task automatic present(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
    bus.in_valid      = 1'b1;
    bus.in_ctrl       = c;
    bus.in_op_a       = a;
    bus.in_op_b       = b;
    bus.in_rd         = rd;
    bus.hold_pipeline = 1'b0;
    #1 check("in_ready_on_offer", bus.in_ready, 1);
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    // scramble decode inputs so a leaky issue register shows up
    bus.in_ctrl   = 6'($urandom);
    bus.in_op_a   = $urandom;
    bus.in_op_b   = $urandom;
    bus.in_rd     = 5'($urandom);
    check("out_valid_after_accept", bus.out_valid, 0);
  endtask

  // h stall cycles (h < MAX_HOLD), then the result must appear on the next edge
  task automatic wait_result(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                             input int h);
    for (int k = 0; k <= h; k++) begin
      bus.hold_pipeline = (k < h);
      #1;
      check("issue_ctrl", bus.ALU_Control, c);
      check("issue_op_a", bus.operand_A, a);
      check("issue_op_b", bus.operand_B, b);
      check("busy_in_ready", bus.in_ready, 0);
      tick();
      if (k < h) check("out_valid_during_hold", bus.out_valid, 0);
    end
    bus.hold_pipeline = 1'b0;
  endtask

  task automatic check_result(input logic [4:0] rd, input res_t e);
    check("out_valid", bus.out_valid, 1);
    check("out_result", bus.out_result, e.res);
    check("out_jalr_target", bus.out_jalr_target, e.jalr);
    check("out_branch_taken", bus.out_branch_taken, e.br);
    check("out_ex", bus.out_ex, e.ex);
    check("out_pc_s_a_1", bus.out_pc_s_a_1, e.ps);
    check("out_zero", bus.out_zero, e.z);
    check("out_rd", bus.out_rd, rd);
  endtask

  task automatic backpressure(input int p, input logic [4:0] rd, input res_t e);
    for (int k = 0; k < p; k++) begin
      bus.out_ready = 1'b0;
      #1 check("done_in_ready_bp", bus.in_ready, 0);
      tick();
      check_result(rd, e);
    end
  endtask

  task automatic retire();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    #1 check("done_in_ready", bus.in_ready, 1);
    tick();
    bus.out_ready = 1'b0;
    check("out_valid_after_retire", bus.out_valid, 0);
    check("idle_alu_ctrl", bus.ALU_Control, ALU_NOP);
    check("idle_in_ready", bus.in_ready, 1);
  endtask

  vec_t        tbl[7];
  logic [5:0]  ops[4];
  vec_t        v;
  res_t        e;
  logic        prev_b2b;
  logic [5:0]  c;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  rd;
  int          h;

  initial begin
    tbl[0] = '{ctrl: ALU_ADD, a: 32'd5, b: 32'd7, rd: 5'd3, holds: 0, bp: 5, b2b: 1'b1,
               exp: '{res: 32'd12, jalr: 32'd12, br: 1'b0, ex: 1'b0, ps: 1'b1, z: 1'b0}};
    tbl[1] = '{ctrl: ALU_SUB, a: 32'd3, b: 32'd3, rd: 5'd9, holds: 2, bp: 1, b2b: 1'b0,
               exp: '{res: 32'd0, jalr: 32'd6, br: 1'b0, ex: 1'b0, ps: 1'b0, z: 1'b1}};
    tbl[2] = '{ctrl: ALU_MUL, a: 32'hFFFF_FFFC, b: 32'd6, rd: 5'd31, holds: 1, bp: 0, b2b: 1'b0,
               exp: '{res: 32'hFFFF_FFE8, jalr: 32'd2, br: 1'b1, ex: 1'b0, ps: 1'b1, z: 1'b0}};
    tbl[3] = '{ctrl: ALU_DIV, a: 32'd100, b: 32'd7, rd: 5'd17, holds: 33, bp: 0, b2b: 1'b0,
               exp: '{res: 32'd14, jalr: 32'd106, br: 1'b0, ex: 1'b0, ps: 1'b0, z: 1'b0}};
    tbl[4] = '{ctrl: ALU_DIV, a: 32'd9, b: 32'd0, rd: 5'd1, holds: 0, bp: 0, b2b: 1'b0,
               exp: '{res: 32'hFFFF_FFFF, jalr: 32'd8, br: 1'b1, ex: 1'b1, ps: 1'b0, z: 1'b0}};
    tbl[5] = '{ctrl: ALU_SUB, a: 32'h8000_0000, b: 32'd1, rd: 5'd5, holds: 0, bp: 0, b2b: 1'b0,
               exp: '{res: 32'h7FFF_FFFF, jalr: 32'h8000_0000, br: 1'b0, ex: 1'b0, ps: 1'b1, z: 1'b0}};
    tbl[6] = '{ctrl: ALU_ADD, a: 32'hFFFF_FFFF, b: 32'd1, rd: 5'd0, holds: 63, bp: 0, b2b: 1'b0,
               exp: '{res: 32'd0, jalr: 32'd0, br: 1'b0, ex: 1'b0, ps: 1'b1, z: 1'b1}};
    ops = '{ALU_ADD, ALU_SUB, ALU_MUL, ALU_DIV};

    bus.in_valid      = 1'b0;
    bus.in_ctrl       = '0;
    bus.in_op_a       = '0;
    bus.in_op_b       = '0;
    bus.in_rd         = '0;
    bus.out_ready     = 1'b0;
    bus.hold_pipeline = 1'b0;
    flush             = 1'b0;
    rst_n             = 1'b0;

    // reset state
    tick();
    tick();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_alu_ctrl", bus.ALU_Control, ALU_NOP);
    check("rst_op_a", bus.operand_A, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_in_ready_held", bus.in_ready, 0);
    rst_n = 1'b1;
    #1 check("in_ready_after_release", bus.in_ready, 1);

    // directed vectors
    prev_b2b = 1'b0;
    for (int i = 0; i < 7; i++) begin
      v = tbl[i];
      if (prev_b2b) bus.out_ready = 1'b1;
      present(v.ctrl, v.a, v.b, v.rd);
      wait_result(v.ctrl, v.a, v.b, v.holds);
      check_result(v.rd, v.exp);
      $display("vec %0d: ctrl=%0h a=%0h b=%0h holds=%0d result=%0h rd=%0d",
               i, v.ctrl, v.a, v.b, v.holds, bus.out_result, bus.out_rd);
      backpressure(v.bp, v.rd, v.exp);
      prev_b2b = v.b2b;
      if (!v.b2b) retire();
    end
    check("no_timeout_at_63_holds", timeout_err, 0);

    // hold stuck high: the 64th hold cycle forces completion with ex set
    present(ALU_DIV, 32'd50, 32'd5, 5'd7);
    for (int k = 0; k < MAX_HOLD; k++) begin
      bus.hold_pipeline = 1'b1;
      #1;
      check("to_op_a", bus.operand_A, 32'd50);
      check("to_timeout_pre", timeout_err, 0);
      tick();
      if (k < MAX_HOLD - 1) check("to_out_valid_pre", bus.out_valid, 0);
    end
    e    = alu_fn(ALU_DIV, 32'd50, 32'd5);
    e.ex = 1'b1;
    check_result(5'd7, e);
    check("to_timeout_set", timeout_err, 1);
    $display("timeout op: result=%0h ex=%0d timeout_err=%0d", bus.out_result, bus.out_ex, timeout_err);
    bus.hold_pipeline = 1'b0;
    retire();
    check("to_sticky_after_retire", timeout_err, 1);
    present(ALU_ADD, 32'd4, 32'd8, 5'd2);
    wait_result(ALU_ADD, 32'd4, 32'd8, 0);
    check_result(5'd2, alu_fn(ALU_ADD, 32'd4, 32'd8));
    retire();
    check("to_sticky_after_op", timeout_err, 1);

    // flush on the 10th hold cycle while a new op is offered
    present(ALU_ADD, 32'd1000, 32'hFFFF_FFFF, 5'd12);
    for (int k = 0; k < 9; k++) begin
      bus.hold_pipeline = 1'b1;
      tick();
      check("fl_out_valid_hold", bus.out_valid, 0);
    end
    flush         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_ctrl   = ALU_SUB;
    bus.in_op_a   = 32'd77;
    bus.in_op_b   = 32'd11;
    tick();
    flush             = 1'b0;
    bus.in_valid      = 1'b0;
    bus.hold_pipeline = 1'b0;
    check("fl_out_valid", bus.out_valid, 0);
    check("fl_alu_ctrl", bus.ALU_Control, ALU_NOP);
    check("fl_op_a", bus.operand_A, 0);
    check("fl_result_dropped", bus.out_result, 0);
    check("fl_timeout_kept", timeout_err, 1);
    #1 check("fl_in_ready", bus.in_ready, 1);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("fl_no_stray_valid", bus.out_valid, 0);
      check("fl_no_stray_issue", bus.ALU_Control, ALU_NOP);
    end
    present(ALU_SUB, 32'd20, 32'd5, 5'd4);
    wait_result(ALU_SUB, 32'd20, 32'd5, 0);
    check_result(5'd4, alu_fn(ALU_SUB, 32'd20, 32'd5));
    $display("post-flush op: result=%0h rd=%0d", bus.out_result, bus.out_rd);
    retire();

    // reset in the middle of a held op
    present(ALU_MUL, 32'd3, 32'd4, 5'd20);
    for (int k = 0; k < 3; k++) begin
      bus.hold_pipeline = 1'b1;
      tick();
    end
    rst_n             = 1'b0;
    bus.hold_pipeline = 1'b0;
    tick();
    check("mr_out_valid", bus.out_valid, 0);
    check("mr_alu_ctrl", bus.ALU_Control, ALU_NOP);
    check("mr_op_a", bus.operand_A, 0);
    check("mr_op_b", bus.operand_B, 0);
    check("mr_out_result", bus.out_result, 0);
    check("mr_out_rd", bus.out_rd, 0);
    check("mr_timeout_cleared", timeout_err, 0);
    check("mr_in_ready_held", bus.in_ready, 0);
    tick();
    rst_n = 1'b1;
    #1 check("mr_in_ready_release", bus.in_ready, 1);
    present(ALU_ADD, 32'd5, 32'd7, 5'd3);
    wait_result(ALU_ADD, 32'd5, 32'd7, 0);
    check_result(5'd3, alu_fn(ALU_ADD, 32'd5, 32'd7));
    retire();

    // randomized ops with random stalls, backpressure and back-to-back issue
    prev_b2b = 1'b0;
    for (int i = 0; i < 40; i++) begin
      c  = ops[$urandom_range(0, 3)];
      a  = $urandom;
      b  = (c == ALU_DIV) ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom;
      rd = 5'($urandom);
      h  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 40)) : int'($urandom_range(0, 3));
      if (prev_b2b) bus.out_ready = 1'b1;
      present(c, a, b, rd);
      e = alu_fn(c, a, b);
      wait_result(c, a, b, h);
      check_result(rd, e);
      $display("rnd %0d: ctrl=%0h a=%0h b=%0h holds=%0d result=%0h rd=%0d",
               i, c, a, b, h, bus.out_result, bus.out_rd);
      backpressure(int'($urandom_range(0, 3)), rd, e);
      prev_b2b = ($urandom_range(0, 1) == 1) && (i != 39);
      if (!prev_b2b) retire();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
